// File: rtl/sram_1r1w_init_pkg.sv
// sram_pkg: shared types and helpers for the 1R1W SRAM model.
// Contents: sram_state_e (init sequencer states), even_par (granule even parity),
// masked_merge (per-granule merge of old/new words under a write mask).
package sram_pkg;
  localparam int MAX_W = 1024;
  typedef enum logic {S_INIT, S_READY} sram_state_e;
  function automatic logic even_par(input logic [MAX_W-1:0] g);
    return ^g;
  endfunction
  // Widths are generic: callers zero-extend into MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] masked_merge(input logic [MAX_W-1:0] old_w, input logic [MAX_W-1:0] new_w,
                                                    input logic [MAX_W-1:0] mask, input int gran_w);
    masked_merge = old_w;
    for (int i = 0; i < MAX_W; i++) if (mask[i/gran_w]) masked_merge[i] = new_w[i];
  endfunction
endpackage

// File: rtl/sram_1r1w_init_if.sv
// sram_1r1w_init_if: request/response bundle of the 1R1W SRAM.
// Signals: init_busy, W0_en/W0_addr/W0_data/W0_mask (write), R0_en/R0_addr (read request),
// R0_data/R0_valid/R0_perr (read response). slave = memory side, master = requester side.
interface sram_1r1w_init_if #(parameter int ADDR_W = 9, parameter int DATA_W = 64, parameter int MASK_W = 8);
  logic              init_busy;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [DATA_W-1:0] R0_data;
  logic              R0_valid;
  logic [MASK_W-1:0] R0_perr;
  modport master(input init_busy, R0_data, R0_valid, R0_perr,
                 output W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr);
  modport slave(output init_busy, R0_data, R0_valid, R0_perr,
                input W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr);
endinterface

// File: rtl/sram_init_seq.sv
// sram_init_seq: post-reset initialisation sequencer, one word per cycle.
// Ports: clock, reset (sync, active-high); init_busy high while sequencing;
// init_we/init_addr drive the init write of INIT_VALUE to word init_addr.
module sram_init_seq import sram_pkg::*; #(
  parameter int DEPTH = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);
  sram_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == S_INIT && cnt_q == ADDR_W'(DEPTH-1)) ? S_READY : state_q;
    cnt_d   = (state_q == S_INIT) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    init_busy = state_q == S_INIT;
    init_we   = state_q == S_INIT;
    init_addr = cnt_q;
  end
endmodule

// File: rtl/sram_1r1w_init.sv
// sram_1r1w_init: 1-read/1-write synchronous SRAM with granule masks, hardware init,
// registered read data, read-during-write forwarding and out-of-range protection.
// Ports: clock, reset (sync, active-high), bus (sram_1r1w_init_if.slave).
// Optional: define SRAM_1R1W_PARITY_EN for per-granule even parity and R0_perr reporting.
module sram_1r1w_init import sram_pkg::*; #(
  parameter int DEPTH = 512,
  parameter int DATA_W = 64,
  parameter int GRAN_W = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int MASK_W = DATA_W / GRAN_W
) (
  input logic              clock,
  input logic              reset,
  sram_1r1w_init_if.slave  bus
);
  logic              busy, init_we, we, re, w_ok, r_ok, fwd, valid_q;
  logic [ADDR_W-1:0] init_addr, waddr;
  logic [DATA_W-1:0] wdata, rd_d, rdata_q;
  logic [MASK_W-1:0] wmask, perr_d, perr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  sram_init_seq #(.DEPTH(DEPTH)) u_seq (
    .clock(clock), .reset(reset), .init_busy(busy), .init_we(init_we), .init_addr(init_addr)
  );
  // While busy the sequencer owns the write port and user requests are dropped.
  always_comb begin
    w_ok  = int'(bus.W0_addr) < DEPTH;
    r_ok  = int'(bus.R0_addr) < DEPTH;
    we    = busy ? init_we : bus.W0_en && w_ok;
    waddr = busy ? init_addr : bus.W0_addr;
    wdata = busy ? INIT_VALUE : bus.W0_data;
    wmask = busy ? '1 : bus.W0_mask;
    re    = !busy && bus.R0_en;
    fwd   = BYPASS != 0 && !busy && bus.W0_en && w_ok && bus.W0_addr == bus.R0_addr;
    rd_d  = !r_ok ? '0 :
            fwd ? DATA_W'(masked_merge(MAX_W'(mem_q[bus.R0_addr]), MAX_W'(bus.W0_data), MAX_W'(bus.W0_mask), GRAN_W)) :
            mem_q[bus.R0_addr];
  end
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= DATA_W'(masked_merge(MAX_W'(mem_q[waddr]), MAX_W'(wdata), MAX_W'(wmask), GRAN_W));
  end
`ifdef SRAM_1R1W_PARITY_EN
  logic [MASK_W-1:0] par_q [DEPTH];
  logic [MASK_W-1:0] wpar;
  always_comb begin
    wpar   = '0;
    perr_d = '0;
    for (int i = 0; i < MASK_W; i++) begin
      wpar[i]   = even_par(MAX_W'(wdata[i*GRAN_W +: GRAN_W]));
      // A forwarded granule carries fresh data and fresh parity, so it cannot mismatch.
      perr_d[i] = r_ok && !(fwd && bus.W0_mask[i]) &&
                  (par_q[bus.R0_addr][i] != even_par(MAX_W'(mem_q[bus.R0_addr][i*GRAN_W +: GRAN_W])));
    end
  end
  always_ff @(posedge clock) begin
    if (we) par_q[waddr] <= MASK_W'(masked_merge(MAX_W'(par_q[waddr]), MAX_W'(wpar), MAX_W'(wmask), 1));
  end
`else
  assign perr_d = '0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      valid_q <= 1'b0;
      perr_q  <= '0;
    end else begin
      valid_q <= re;
      if (re) begin
        rdata_q <= rd_d;
        perr_q  <= perr_d;
      end
    end
  end
  assign bus.init_busy = busy;
  assign bus.R0_data   = rdata_q;
  assign bus.R0_valid  = valid_q;
  assign bus.R0_perr   = perr_q;
endmodule

// File: tb/tb_sram_1r1w_init.sv
// tb_sram_1r1w_init: self-checking bench for sram_1r1w_init (DEPTH=512 bypassing, DEPTH=300 non-bypassing).
module tb_sram_1r1w_init;
  localparam logic [63:0] IV = 64'hA5A5_A5A5_A5A5_A5A5;
  logic        clk = 0, rst_a = 1, rst_b = 1, sel = 0, w_en = 0, r_en = 0;
  logic [8:0]  w_addr = '0, r_addr = '0;
  logic [63:0] w_data = '0, last_rd = '0, held;
  logic [7:0]  w_mask = '0, eperr = '0;
  logic [63:0] mdl [2][512];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  sram_1r1w_init_if #(.ADDR_W(9), .DATA_W(64), .MASK_W(8)) ifa ();
  sram_1r1w_init_if #(.ADDR_W(9), .DATA_W(64), .MASK_W(8)) ifb ();
  assign ifa.W0_en = w_en && !sel;
  assign ifa.R0_en = r_en && !sel;
  assign ifb.W0_en = w_en && sel;
  assign ifb.R0_en = r_en && sel;
  assign ifa.W0_addr = w_addr;
  assign ifb.W0_addr = w_addr;
  assign ifa.W0_data = w_data;
  assign ifb.W0_data = w_data;
  assign ifa.W0_mask = w_mask;
  assign ifb.W0_mask = w_mask;
  assign ifa.R0_addr = r_addr;
  assign ifb.R0_addr = r_addr;
  sram_1r1w_init #(.DEPTH(512), .DATA_W(64), .GRAN_W(8), .INIT_VALUE(IV), .BYPASS(1))
    dut_a (.clock(clk), .reset(rst_a), .bus(ifa));
  sram_1r1w_init #(.DEPTH(300), .DATA_W(64), .GRAN_W(8), .INIT_VALUE(64'h0), .BYPASS(0))
    dut_b (.clock(clk), .reset(rst_b), .bus(ifb));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // One cycle of traffic on DUT s (0: depth 512 bypass, 1: depth 300 no bypass), checked against the model.
  task automatic op(input string tag, input bit s, input bit we, input logic [8:0] wa, input logic [63:0] wd,
                    input logic [7:0] wm, input bit re, input logic [8:0] ra);
    int d;
    bit byp;
    logic [63:0] e;
    d = s ? 300 : 512;
    byp = (s == 1'b0);
    e = '0;
    if (ra < d) begin
      e = mdl[s][ra];
      if (byp && we && wa == ra) for (int g = 0; g < 8; g++) if (wm[g]) e[g*8 +: 8] = wd[g*8 +: 8];
    end
    sel = s; w_en = we; w_addr = wa; w_data = wd; w_mask = wm; r_en = re; r_addr = ra;
    @(posedge clk); #1;
    w_en = 0; r_en = 0;
    if (we && wa < d) for (int g = 0; g < 8; g++) if (wm[g]) mdl[s][wa][g*8 +: 8] = wd[g*8 +: 8];
    chk({tag, "_valid"}, s ? ifb.R0_valid : ifa.R0_valid, re);
    if (re) begin
      last_rd = s ? ifb.R0_data : ifa.R0_data;
      chk({tag, "_data"}, last_rd, e);
      chk({tag, "_perr"}, s ? ifb.R0_perr : ifa.R0_perr, eperr);
    end
  endtask
  // Reset DUT a (and b on the first call), then run init; abort_at >= 0 stops early for a mid-init reset.
  task automatic init_a(input int abort_at, input bit first);
    int n;
    n = 0;
    rst_a = 1;
    if (first) rst_b = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", ifa.init_busy, 1);
    chk("rst_data", ifa.R0_data, 0);
    chk("rst_valid", ifa.R0_valid, 0);
    chk("rst_perr", ifa.R0_perr, 0);
    rst_a = 0;
    if (first) rst_b = 0;
    while (ifa.init_busy && n < 2000 && n != abort_at) begin
      if (n == 10) begin
        sel = 0; w_en = 1; w_addr = 5; w_data = '1; w_mask = '1; r_en = 1; r_addr = 5;
      end
      @(posedge clk); #1;
      n++;
      if (n == 11) begin
        chk("busy_drop_valid", ifa.R0_valid, 0);
        w_en = 0; r_en = 0;
      end
    end
    if (abort_at < 0) chk("init_len", n, 512);
    for (int i = 0; i < 512; i++) begin
      mdl[0][i] = IV;
      if (first) mdl[1][i] = '0;
    end
  endtask
  initial begin
    bit s, we, re;
    logic [8:0] wa, ra;
    init_a(-1, 1);
    chk("b_ready", ifb.init_busy, 0);
    op("init0", 0, 0, 0, 0, 0, 1, 0);
    chk("init0_lit", last_rd, IV);
    op("init255", 0, 0, 0, 0, 0, 1, 255);
    op("init511", 0, 0, 0, 0, 0, 1, 511);
    chk("init511_lit", last_rd, IV);
    op("busy_addr5", 0, 0, 0, 0, 0, 1, 5);
    chk("busy_addr5_lit", last_rd, IV);
    op("mw1", 0, 1, 3, 64'h1122334455667788, 8'hFF, 0, 0);
    op("mw2", 0, 1, 3, '1, 8'h0F, 0, 0);
    op("mw_rd", 0, 0, 0, 0, 0, 1, 3);
    chk("mw_lit", last_rd, 64'h11223344FFFFFFFF);
    held = last_rd;
    op("hold_wr", 0, 1, 3, 64'h0, 8'hFF, 0, 0);
    chk("hold", ifa.R0_data, held);
    op("rdw_clr", 0, 1, 7, 64'h0, 8'hFF, 0, 0);
    op("rdw_a", 0, 1, 7, '1, 8'h01, 1, 7);
    chk("rdw_a_lit", last_rd, 64'hFF);
    op("rdw_a2", 0, 0, 0, 0, 0, 1, 7);
    chk("rdw_a2_lit", last_rd, 64'hFF);
    op("rdw_b", 1, 1, 7, '1, 8'h01, 1, 7);
    chk("rdw_b_lit", last_rd, 64'h0);
    op("rdw_b2", 1, 0, 0, 0, 0, 1, 7);
    chk("rdw_b2_lit", last_rd, 64'hFF);
    op("oor_wr", 1, 1, 310, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0);
    op("oor_rd", 1, 0, 0, 0, 0, 1, 310);
    chk("oor_lit", last_rd, 64'h0);
    op("alias10", 1, 0, 0, 0, 0, 1, 10);
    chk("alias10_lit", last_rd, 64'h0);
    for (int k = 0; k < 400; k++) begin
      s  = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = s ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511));
      ra = ($urandom_range(0, 3) == 0) ? wa : (s ? 9'($urandom_range(0, 319)) : 9'($urandom_range(0, 511)));
      op("rand", s, we, wa, {$urandom, $urandom}, 8'($urandom), re, ra);
    end
`ifdef SRAM_1R1W_PARITY_EN
    dut_a.mem_q[4][9] = ~dut_a.mem_q[4][9];
    mdl[0][4][9] = ~mdl[0][4][9];
    eperr = 8'h02;
    op("par_err", 0, 0, 0, 0, 0, 1, 4);
    eperr = 8'h00;
    op("par_clean", 0, 0, 0, 0, 0, 1, 6);
    op("par_fix", 0, 1, 4, 64'h55, 8'hFF, 1, 4);
`endif
    op("rt_wr9", 0, 1, 9, 64'h1234, 8'hFF, 0, 0);
    op("rt_rd9", 0, 0, 0, 0, 0, 1, 9);
    chk("rt_rd9_lit", last_rd, 64'h1234);
    init_a(100, 0);
    init_a(-1, 0);
    op("post_rst9", 0, 0, 0, 0, 0, 1, 9);
    chk("post_rst9_lit", last_rd, IV);
    op("post_rst3", 0, 0, 0, 0, 0, 1, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
